// File: rtl/output_cdf_sequencer.sv
// Output CDF sequencer: reads every pixel of a frame from pixel memory, uses
// each pixel value as the address of a CDF-memory read, and signals the output
// fetch stage once per pixel when the CDF data is valid.
//
// Ports
//   clock       : clock; all state updates on its rising edge
//   reset_n     : asynchronous active-low reset
//   Go          : frame-start pulse, honoured only when idle
//   PixelCount  : pixels in the frame, sampled on the accepted Go
//   Stall       : suppresses issue of new pixel reads
//   PixRdEn     : pixel-memory read strobe
//   PixAddr     : pixel-memory read address (0 when PixRdEn is low)
//   PixData     : pixel value, valid the cycle after PixRdEn
//   CdfRdEn     : CDF-memory read strobe (two cycles after PixRdEn)
//   CdfAddr     : CDF-memory read address = pixel value (0 when CdfRdEn is low)
//   StartFetch  : output fetch start, three cycles after PixRdEn
//   Busy        : high whenever a frame is in progress
//   Done        : one-cycle end-of-frame pulse
module output_cdf_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        Go,
    input  logic [15:0] PixelCount,
    input  logic        Stall,
    output logic        PixRdEn,
    output logic [15:0] PixAddr,
    input  logic [7:0]  PixData,
    output logic        CdfRdEn,
    output logic [7:0]  CdfAddr,
    output logic        StartFetch,
    output logic        Busy,
    output logic        Done
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned PIX_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               rd_issue;
    logic               rd_vld_q;      // pixel data arrives this cycle
    logic               cdf_vld_q;     // CDF read issued this cycle
    logic [PIX_W-1:0]   cdf_addr_q;
    logic               fetch_q;       // CDF data valid this cycle

    // State, counters and read pipeline; the pipeline advances every cycle
    // so in-flight reads always complete even while stalled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            rd_vld_q   <= 1'b0;
            cdf_vld_q  <= 1'b0;
            cdf_addr_q <= '0;
            fetch_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            rd_vld_q   <= rd_issue;
            cdf_vld_q  <= rd_vld_q;
            cdf_addr_q <= rd_vld_q ? PixData : PIX_W'(0);
            fetch_q    <= cdf_vld_q;
        end
    end

    // Next-state and read-issue decode.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        rd_issue = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Go) begin
                    count_d = PixelCount;
                    addr_d  = '0;
                    state_d = (PixelCount == CNT_W'(0)) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (!Stall) begin
                    rd_issue = 1'b1;
                    addr_d   = addr_q + CNT_W'(1);
                    // count_q >= 1 here, so count_q-1 never underflows and
                    // the address never needs to wrap.
                    if (addr_q == count_q - CNT_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // StartFetch of the last read is emitted in the cycle that
                // both earlier stages are empty.
                if (!rd_vld_q && !cdf_vld_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The pixel read strobe follows Stall within the cycle; everything else
    // is a register or a decode of the state register.
    assign PixRdEn    = rd_issue;
    assign PixAddr    = rd_issue ? addr_q : CNT_W'(0);
    assign CdfRdEn    = cdf_vld_q;
    assign CdfAddr    = cdf_addr_q;
    assign StartFetch = fetch_q;
    assign Busy       = (state_q != S_IDLE);
    assign Done       = (state_q == S_DONE);

endmodule

// File: tb/tb_output_cdf_sequencer.sv
// Self-checking bench for output_cdf_sequencer: directed frames plus random
// frames with random stalls and stray Go pulses, checked every cycle against
// an event-schedule reference model.
module tb_output_cdf_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        Go;
    logic [15:0] PixelCount;
    logic        Stall;
    logic        PixRdEn;
    logic [15:0] PixAddr;
    logic [7:0]  PixData;
    logic        CdfRdEn;
    logic [7:0]  CdfAddr;
    logic        StartFetch;
    logic        Busy;
    logic        Done;

    output_cdf_sequencer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .Go         (Go),
        .PixelCount (PixelCount),
        .Stall      (Stall),
        .PixRdEn    (PixRdEn),
        .PixAddr    (PixAddr),
        .PixData    (PixData),
        .CdfRdEn    (CdfRdEn),
        .CdfAddr    (CdfAddr),
        .StartFetch (StartFetch),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] mem [65536];

    // Reference model: one frame described by its Go cycle, reads left,
    // next address and (once known) its Done cycle; downstream events are
    // scheduled by absolute cycle number.
    bit   m_active;
    int   m_go_cyc;
    int   m_reads_left;
    int   m_next_addr;
    int   m_done_cyc;
    int   m_pc;
    int   sf_cnt;
    logic [7:0] sched_cdf [int];
    bit         sched_start [int];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        m_active     = 1'b0;
        m_go_cyc     = 0;
        m_reads_left = 0;
        m_next_addr  = 0;
        m_done_cyc   = -1;
        sched_cdf.delete();
        sched_start.delete();
    endtask

    // One clock cycle: drive inputs, check outputs, advance model.
    task automatic tick(input logic go, input logic [15:0] pc, input logic stall, input logic rst);
        bit         exp_rd, exp_busy, exp_done, exp_cdf, exp_sf;
        logic [7:0] exp_cdf_addr;
        logic       rd_seen;
        logic [15:0] rd_addr;
        @(negedge clock);
        Go         = go;
        PixelCount = pc;
        Stall      = stall;
        reset_n    = rst;
        #1;
        if (!rst) model_clear();
        exp_rd       = m_active && (cyc > m_go_cyc) && (m_reads_left > 0) && !stall;
        exp_busy     = m_active && (cyc > m_go_cyc);
        exp_done     = m_active && (cyc == m_done_cyc);
        exp_cdf      = sched_cdf.exists(cyc);
        exp_cdf_addr = exp_cdf ? sched_cdf[cyc] : 8'h00;
        exp_sf       = sched_start.exists(cyc);
        chk("PixRdEn",    32'(PixRdEn),    32'(exp_rd));
        chk("PixAddr",    32'(PixAddr),    exp_rd ? 32'(m_next_addr) : 32'd0);
        chk("CdfRdEn",    32'(CdfRdEn),    32'(exp_cdf));
        chk("CdfAddr",    32'(CdfAddr),    32'(exp_cdf_addr));
        chk("StartFetch", 32'(StartFetch), 32'(exp_sf));
        chk("Busy",       32'(Busy),       32'(exp_busy));
        chk("Done",       32'(Done),       32'(exp_done));
        rd_seen = PixRdEn;
        rd_addr = PixAddr;
        if (rst) begin
            if (exp_cdf) sched_cdf.delete(cyc);
            if (exp_sf)  sched_start.delete(cyc);
            if (StartFetch) sf_cnt++;
            if (exp_rd) begin
                sched_cdf[cyc + 2]   = mem[m_next_addr];
                sched_start[cyc + 3] = 1'b1;
                m_next_addr++;
                m_reads_left--;
                if (m_reads_left == 0) m_done_cyc = cyc + 4;
            end
            if (exp_done) begin
                chk("sf_total", 32'(sf_cnt), 32'(m_pc));
                m_active = 1'b0;
            end else if (!m_active && go) begin
                m_active     = 1'b1;
                m_go_cyc     = cyc;
                m_pc         = int'(pc);
                m_reads_left = int'(pc);
                m_next_addr  = 0;
                m_done_cyc   = (pc == 16'd0) ? cyc + 2 : -1;
                sf_cnt       = 0;
            end
        end
        @(posedge clock);
        #1;
        // Pixel memory: data for the address read in the previous cycle,
        // junk otherwise so an ungated CdfAddr shows up.
        PixData = rd_seen ? mem[rd_addr] : 8'($urandom);
        cyc++;
    endtask

    // Run until the model reports the frame finished, bounded.
    task automatic finish_frame(input int stall_pct, input bit stray_go);
        int budget;
        budget = 10 * m_pc + 50;
        while (m_active && budget > 0) begin
            tick(stray_go && ($urandom_range(7) == 0), 16'(9), ($urandom_range(99) < stall_pct), 1'b1);
            budget--;
        end
        if (m_active) begin
            chk("frame_timeout", 32'd1, 32'd0);
            tick(1'b0, 16'd0, 1'b0, 1'b0);
            tick(1'b0, 16'd0, 1'b0, 1'b1);
        end
    endtask

    task automatic run_frame(input logic [15:0] pc, input int stall_pct, input bit stray_go);
        tick(1'b1, pc, 1'b0, 1'b1);
        finish_frame(stall_pct, stray_go);
    endtask

    initial begin
        reset_n    = 1'b0;
        Go         = 1'b0;
        Stall      = 1'b0;
        PixelCount = 16'd0;
        PixData    = 8'd0;
        sf_cnt     = 0;
        m_pc       = 0;
        model_clear();
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        // Reset state, then release with a few idle cycles
        tick(1'b0, 16'd0, 1'b0, 1'b0);
        tick(1'b1, 16'd3, 1'b0, 1'b0);
        tick(1'b0, 16'd0, 1'b0, 1'b1);
        tick(1'b0, 16'd0, 1'b0, 1'b1);

        // Four pixels with known values, no stall
        mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'h40;
        run_frame(16'd4, 0, 1'b0);
        tick(1'b0, 16'd0, 1'b0, 1'b1);

        // Five pixels, two stall cycles after the second read
        tick(1'b1, 16'd5, 1'b0, 1'b1);
        tick(1'b0, 16'd5, 1'b0, 1'b1);
        tick(1'b0, 16'd5, 1'b0, 1'b1);
        tick(1'b0, 16'd5, 1'b1, 1'b1);
        tick(1'b0, 16'd5, 1'b1, 1'b1);
        finish_frame(0, 1'b0);
        tick(1'b0, 16'd0, 1'b0, 1'b1);

        // Empty frame
        run_frame(16'd0, 0, 1'b0);
        tick(1'b0, 16'd0, 1'b0, 1'b1);

        // Go with PixelCount=9 mid-frame is ignored
        tick(1'b1, 16'd6, 1'b0, 1'b1);
        tick(1'b0, 16'd6, 1'b0, 1'b1);
        tick(1'b1, 16'd9, 1'b0, 1'b1);
        tick(1'b1, 16'd9, 1'b1, 1'b1);
        finish_frame(0, 1'b0);

        // Reset one cycle after the third read of an 8-pixel frame
        tick(1'b1, 16'd8, 1'b0, 1'b1);
        tick(1'b0, 16'd8, 1'b0, 1'b1);
        tick(1'b0, 16'd8, 1'b0, 1'b1);
        tick(1'b0, 16'd8, 1'b0, 1'b1);
        tick(1'b0, 16'd8, 1'b0, 1'b0);
        tick(1'b0, 16'd8, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b0, 16'd0, 1'b0, 1'b1);
        run_frame(16'd2, 0, 1'b0);

        // Back-to-back frames: Go in the cycle right after Done
        run_frame(16'd3, 0, 1'b0);
        run_frame(16'd5, 0, 1'b0);

        // Frame crossing an 8-bit address boundary
        run_frame(16'd300, 20, 1'b1);

        // Random frames with random stalls and stray Go pulses
        for (int f = 0; f < 25; f++) begin
            run_frame(16'($urandom_range(40)), int'($urandom_range(60)), 1'b1);
            if ($urandom_range(1) == 1) tick(1'b0, 16'd0, 1'($urandom), 1'b1);
        end
        tick(1'b0, 16'd0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
